// File: rtl/risc_alu_seq.sv
// Registered RiSC-16 style ALU with valid/ready handshakes and zero/carry flags.
// Define RISC_ALU_MUL_EN to build the iterative shift-add multiplier for op 111.
module risc_alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c
);

    // state  | meaning
    // IDLE   | no result held, ready for an operation
    // BUSY   | multiply in progress, one bit of b per cycle
    // DONE   | result/flags valid, held until out_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_EQ   = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;

    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic [WIDTH:0]   sum_add;
    logic [2*WIDTH-1:0] shl_full;
    logic [2*WIDTH-1:0] shr_full;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;

    // Widened shifts keep the shifted-out bits so the carry is a simple OR.
    assign sum_add  = {1'b0, a} + {1'b0, b};
    assign shl_full = {{WIDTH{1'b0}}, a} << b[SHW-1:0];
    assign shr_full = {a, {WIDTH{1'b0}}} >> b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD:  {alu_c, alu_res} = sum_add;
            OP_NAND: alu_res = ~(a & b);
            OP_EQ:   alu_res = {WIDTH{a == b}};
            OP_PASS: alu_res = a;
            OP_SUB: begin
                alu_res = a - b;
                alu_c   = (a < b);
            end
            OP_SHL: begin
                alu_res = shl_full[WIDTH-1:0];
                alu_c   = |shl_full[2*WIDTH-1:WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_full[2*WIDTH-1:WIDTH];
                alu_c   = |shr_full[WIDTH-1:0];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b1;
            end
        endcase
    end

`ifdef RISC_ALU_MUL_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic               mul_last;

    assign is_mul = (op == 3'b111);

    // Product register: upper half accumulates, lower half holds the
    // not-yet-consumed multiplier bits; both shift right each step.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};
    assign mul_last = (state_q == S_BUSY) && (cnt_q == '0);

    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        if (accept && is_mul) begin
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = SHW'(WIDTH - 1);
        end else if (state_q == S_BUSY) begin
            prod_d = mul_step;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = S_BUSY;
                    end else begin
                        state_d  = S_DONE;
                        result_d = alu_res;
                        flag_z_d = (alu_res == '0);
                        flag_c_d = alu_c;
                    end
                end else if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
`ifdef RISC_ALU_MUL_EN
                if (mul_last) begin
                    state_d  = S_DONE;
                    result_d = mul_step[WIDTH-1:0];
                    flag_z_d = (mul_step[WIDTH-1:0] == '0);
                    flag_c_d = |mul_step[2*WIDTH-1:WIDTH];
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

endmodule

// File: tb/tb_risc_alu_seq.sv
// Scoreboard bench for risc_alu_seq (WIDTH=16); follows RISC_ALU_MUL_EN for op 111 expectations.
module tb_risc_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_c;

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] sb_q[$];

    risc_alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: returns {carry, zero, result}.
    function automatic logic [17:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        logic [16:0] s;
        logic [31:0] p;
        int          sh;
        r  = '0;
        c  = 1'b0;
        sh = int'(y[3:0]);
        case (o)
            3'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[15:0]; c = s[16]; end
            3'd1: r = ~(x & y);
            3'd2: r = (x == y) ? 16'hFFFF : 16'h0000;
            3'd3: r = x;
            3'd4: begin r = x - y; c = (x < y); end
            3'd5: begin
                r = x << sh;
                for (int i = 0; i < sh; i++) c = c | x[15-i];
            end
            3'd6: begin
                r = x >> sh;
                for (int i = 0; i < sh; i++) c = c | x[i];
            end
            default: begin
`ifdef RISC_ALU_MUL_EN
                p = 32'(x) * 32'(y);
                r = p[15:0];
                c = |p[31:16];
`else
                r = 16'h0000;
                c = 1'b1;
`endif
            end
        endcase
        return {c, (r == 16'h0000), r};
    endfunction

    // Drives one operation, waits (bounded) for acceptance, returns at posedge+1 of the accept edge.
    task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        int n;
        n        = 0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_val("issue_timeout", 32'(in_ready), 32'd1);
        else sb_q.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [17:0] e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underrun", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_result", 32'(result), 32'(e[15:0]));
                check_val("sb_flag_z", 32'(flag_z), 32'(e[16]));
                check_val("sb_flag_c", 32'(flag_c), 32'(e[17]));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    logic [2:0]  dir_op[$];
    logic [15:0] dir_a[$];
    logic [15:0] dir_b[$];

    initial begin
        int n;
        int bad;
        logic [2:0] ro;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_result", 32'(result), 32'd0);
        @(posedge clk);
        #1;

        // Leave a result held in DONE, then reset asynchronously mid-cycle.
        issue(3'd4, 16'd3, 16'd5);
        @(negedge clk);
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        check_val("pre_rst_result", 32'(result), 32'hFFFE);
        check_val("pre_rst_flag_c", 32'(flag_c), 32'd1);
        #2 rst = 1'b1;
        sb_q.delete();
        #1;
        check_val("async_rst_valid", 32'(out_valid), 32'd0);
        check_val("async_rst_result", 32'(result), 32'd0);
        check_val("async_rst_flag_z", 32'(flag_z), 32'd0);
        check_val("async_rst_flag_c", 32'(flag_c), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed single-cycle ops, each checked for latency 1.
        out_ready = 1'b1;
        dir_op = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd5, 3'd6, 3'd1, 3'd2, 3'd2, 3'd3};
        dir_a  = '{16'hFFFF, 16'd3, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'hFF00, 16'h1234, 16'd9, 16'h0000};
        dir_b  = '{16'h0001, 16'd5, 16'd1, 16'd1, 16'h0010, 16'h0010, 16'h0FF0, 16'h1234, 16'd8, 16'h5555};
`ifndef RISC_ALU_MUL_EN
        dir_op.push_back(3'd7);
        dir_a.push_back(16'd300);
        dir_b.push_back(16'd300);
`endif
        foreach (dir_op[i]) begin
            issue(dir_op[i], dir_a[i], dir_b[i]);
            @(negedge clk);
            check_val("lat1_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end

`ifdef RISC_ALU_MUL_EN
        issue(3'd7, 16'd300, 16'd300);
        n   = 1;
        bad = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            if (in_ready) bad++;
            @(negedge clk);
            n++;
        end
        check_val("mul_latency", 32'(n), 32'd17);
        check_val("mul_busy_in_ready", 32'(bad), 32'd0);
        check_val("mul_result", 32'(result), 32'h5F90);
        check_val("mul_flag_c", 32'(flag_c), 32'd1);
        @(posedge clk);
        #1;
`endif

        // Backpressure in DONE, then a back-to-back accept.
        out_ready = 1'b0;
        issue(3'd0, 16'h1234, 16'h1111);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_result", 32'(result), 32'h2345);
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
            check_val("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(3'd1, 16'hFF00, 16'h0FF0);
        @(negedge clk);
        check_val("b2b_out_valid", 32'(out_valid), 32'd1);
        check_val("b2b_result", 32'(result), 32'hF0FF);
        @(posedge clk);
        #1;

`ifdef RISC_ALU_MUL_EN
        // Abandon a multiply with reset; no result may appear afterwards.
        issue(3'd7, 16'd300, 16'd300);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        sb_q.delete();
        #1 check_val("mul_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check_val("mul_rst_no_valid", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
`endif
        issue(3'd2, 16'd7, 16'd7);
        @(negedge clk);
        check_val("eq_valid", 32'(out_valid), 32'd1);
        check_val("eq_result", 32'(result), 32'hFFFF);
        check_val("eq_flag_c", 32'(flag_c), 32'd0);
        @(posedge clk);
        #1;

        // Random back-to-back traffic with the consumer always ready.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            if (i % 4 == 0) issue(ro, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)));
            else issue(ro, 16'($urandom), 16'($urandom));
        end

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
